// File: rtl/mont_mul_engine.sv
// mont_mul_engine: digit-serial Montgomery engine (MUL a*b/R, TO_MONT a*R, FROM_MONT a/R, all mod N)
module mont_mul_engine #(
    parameter int WIDTH = 512,
    parameter int DIGIT = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] n_prime_in,
    input  logic [WIDTH-1:0] r2_in,
    output logic [WIDTH-1:0] x_out,
    output logic             valid_out,
    output logic             busy_out
);
    localparam int K  = WIDTH / DIGIT;
    localparam int CW = $clog2(K + 1);
    localparam int EW = WIDTH + DIGIT + 2;

    if ((WIDTH % DIGIT != 0) ||
        (DIGIT != 1 && DIGIT != 2 && DIGIT != 4 && DIGIT != 8 && DIGIT != 16)) begin : g_bad_params
        $error("mont_mul_engine: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, x_q, x_d;
    logic [DIGIT-1:0] np_q, np_d;
    logic [WIDTH+1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [EW-1:0]    t, u;
    logic [DIGIT-1:0] q;
    logic             unused_ok;

    always_comb begin
        t = EW'(s_q) + EW'(a_q[DIGIT-1:0]) * EW'(b_q);
        // q cancels the low digit of T, since n' is the true inverse of N
        q = -(t[DIGIT-1:0] * np_q);
        u = t + EW'(q) * EW'(n_q);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        np_d    = np_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (valid_in) begin
                state_d = ITER;
                a_d     = a_in;
                n_d     = n_in;
                np_d    = n_prime_in[DIGIT-1:0];
                b_d     = mode_in == 2'b01 ? r2_in : mode_in == 2'b10 ? WIDTH'(1) : b_in;
                s_d     = '0;
                cnt_d   = '0;
            end
            ITER: begin
                a_d     = a_q >> DIGIT;
                s_d     = u[EW-1:DIGIT];
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == CW'(K - 1) ? FINAL : ITER;
            end
            FINAL: begin
                x_d     = s_q >= {2'b00, n_q} ? WIDTH'(s_q - {2'b00, n_q}) : s_q[WIDTH-1:0];
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            np_q    <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            np_q    <= np_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            valid_q <= valid_d;
        end
    end

    assign x_out     = x_q;
    assign valid_out = valid_q;
    assign busy_out  = state_q != IDLE;
    assign unused_ok = ^{u[DIGIT-1:0], n_prime_in >> DIGIT};
endmodule

// File: doc/mont_mul_engine.md
Name: mont_mul_engine

Overview:
- Parametrised digit-serial Montgomery engine; successor to the fixed reduction-only block.
- One datapath serves three modes:
  - MUL: a·b·R⁻¹ mod N
  - TO_MONT: a·R mod N
  - FROM_MONT: a·R⁻¹ mod N
- Radix 2^DIGIT sets the area/latency trade-off.
- Sits between the modular-exponentiation controller and the operand registers; one operation in flight at a time.

Parameters:
- WIDTH, 512: operand/modulus width in bits. R = 2^WIDTH.
- DIGIT, 1: bits of operand a consumed per iteration.
  - Legal values: 1, 2, 4, 8, 16.
  - WIDTH % DIGIT == 0 is required; elaboration fails otherwise.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- valid_in  input  1  request strobe; sampled on rising clk_in
- mode_in  input  2  operation select: 00 MUL, 01 TO_MONT, 10 FROM_MONT, 11 treated as MUL
- a_in  input  WIDTH  operand a; must be < N
- b_in  input  WIDTH  operand b; used in MUL only; must be < N
- n_in  input  WIDTH  modulus N; odd; N < R
- n_prime_in  input  WIDTH  N⁻¹ mod R (N·N' ≡ 1 mod R); only bits [DIGIT-1:0] are used
- r2_in  input  WIDTH  R² mod N; used in TO_MONT only
- x_out  output  WIDTH  result, fully reduced to [0, N)
- valid_out  output  1  one-cycle pulse when x_out is updated
- busy_out  output  1  high while an operation is in progress

Behaviour:
- Reset (rst_in high at a clock edge):
  - state → IDLE; x_out = 0, valid_out = 0, busy_out = 0.
  - Any operation in flight is aborted; its result is never produced.
- Accept condition: valid_in = 1 while in IDLE.
  - On that edge, capture a_in, n_in, n_prime_in[DIGIT-1:0], and an effective multiplicand B:
    - MUL and mode 11: B = b_in.
    - TO_MONT: B = r2_in.
    - FROM_MONT: B = 1.
  - Clear the accumulator S (WIDTH+2 bits) and the digit counter.
  - Move to ITER.
- valid_in outside IDLE is ignored: no queuing, no effect on the running operation.
- ITER: runs exactly K = WIDTH/DIGIT cycles. On each cycle, with a_i = digit i of a (LSB digit first):
  - T = S + a_i·B
  - q = (−T·n') mod 2^DIGIT
  - S ← (T + q·N) >> DIGIT
  - The low DIGIT bits of T + q·N must be zero. S stays < 2N throughout.
  - After the K-th iteration, go to FINAL.
- FINAL (1 cycle):
  - x_out ← (S ≥ N) ? S − N : S[WIDTH-1:0].
  - valid_out = 1 on the following cycle; state → IDLE.
- Timing from the accepting edge at cycle 0:
  - busy_out is high in cycles 1..K+1.
  - valid_out is high in cycle K+2 only.
  - busy_out is low in cycle K+2, so a new valid_in in cycle K+2 is accepted: back-to-back throughput is one result per K+2 cycles.
- x_out holds its value until the next FINAL or a reset.
- Inputs other than valid_in/mode_in need only be stable at the accepting edge.
- Out-of-contract inputs (even N, a ≥ N, b ≥ N):
  - The result is undefined.
  - The timing above must still hold; the engine must not hang.

Test Plan:
- WIDTH=16, DIGIT=1, N=33227, N'=39907, FROM_MONT a=24226 → x_out=46; valid_out exactly 18 cycles after accept, busy_out high in cycles 1–17.
- Same N, TO_MONT a=46, r2_in=12049 → x_out=24226. Repeat with DIGIT=4 → same value at 6-cycle latency.
- Same N, MUL a=24226, b=32309 (R mod N, i.e. Montgomery 1) → 24226. Corner cases:
  - FROM_MONT a=32309 → 1.
  - FROM_MONT a=0 → 0.
  - MUL a=b=33226 → (N−1)²·R⁻¹ mod N per the golden model; this exercises the final subtract.
- Back-to-back and ignored requests:
  - Issue a second valid_in in the valid_out cycle → accepted; second result follows K+2 cycles later.
  - valid_in pulses during ITER → ignored; busy_out and the result are unaffected.
- Reset mid-operation:
  - Assert rst_in at iteration K/2 → next cycle busy_out=0, x_out=0, and no valid_out appears for the aborted operation.
  - A fresh request afterwards completes correctly.
- WIDTH=512 with DIGIT ∈ {1, 8}, 200 random odd N with matching N' and R² mod N, all three modes against a software golden model → bit-exact x_out, latency K+2.
